// File: rtl/rhythm_player_pkg.sv
// Shared constants and command encoding for the clap-rhythm player.
package rhythm_player_pkg;

    localparam int SLOTS      = 10;
    localparam int TW         = 8;
    localparam int MIN_GAP    = 5;
    localparam int BEEP_TICKS = 4;
    localparam int CW         = 4;
    localparam int BW         = $clog2(BEEP_TICKS + 1);

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_READY  = 3'd1,
        CMD_FIND   = 3'd2,
        CMD_RETURN = 3'd3,
        CMD_STOP   = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_e;

    function automatic logic cmd_ok(input logic [2:0] c);
        return (c >= CMD_READY) && (c <= CMD_STOP);
    endfunction

    function automatic logic [1:0] cmd_sel(input logic [2:0] c);
        return 2'(c - 3'd1);
    endfunction

endpackage

// File: rtl/rhythm_player_pattern_store.sv
// Per-command timestamp register file with ordered-push and clear rules.
module pattern_store
    import rhythm_player_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_clr,
    input  logic          ld_push,
    input  logic [2:0]    ld_cmd,
    input  logic [TW-1:0] ld_time,
    input  logic          lock,
    input  logic [2:0]    lock_cmd,
    output logic          ld_ack,
    input  logic [2:0]    rd_cmd,
    input  logic [CW-1:0] rd_idx,
    output logic [TW-1:0] rd_time,
    output logic [CW-1:0] rd_cnt,
    input  logic [2:0]    q_cmd,
    output logic [CW-1:0] q_cnt
);

    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [TW-1:0] mem_q [4][SLOTS];
    logic          ack_q, ack_d;
    logic          we;
    logic [1:0]    sel;
    logic [CW-1:0] cur;
    logic [TW-1:0] last;

    always_comb begin
        cnt_d = cnt_q;
        ack_d = 1'b0;
        we    = 1'b0;
        sel   = cmd_sel(ld_cmd);
        cur   = cnt_q[sel];
        last  = (cur != '0) ? mem_q[sel][cur - 1'b1] : '0;
        // the pattern currently being replayed is frozen
        if (cmd_ok(ld_cmd) && !(lock && ld_cmd == lock_cmd)) begin
            if (ld_clr) begin
                cnt_d[sel] = '0;
                ack_d      = 1'b1;
            end else if (ld_push && cur < CW'(SLOTS) &&
                         (cur == '0 || {1'b0, ld_time} > {1'b0, last} + (TW+1)'(MIN_GAP))) begin
                we         = 1'b1;
                cnt_d[sel] = cur + 1'b1;
                ack_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            ack_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ack_q <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[sel][cur] <= ld_time;
    end

    assign ld_ack  = ack_q;
    assign rd_time = mem_q[cmd_sel(rd_cmd)][rd_idx];
    assign rd_cnt  = cnt_q[cmd_sel(rd_cmd)];
    assign q_cnt   = cmd_ok(q_cmd) ? cnt_q[cmd_sel(q_cmd)] : '0;

endmodule

// File: rtl/rhythm_player.sv
// Replays a stored clap pattern as buzzer pulses on the tick timebase.
module rhythm_player
    import rhythm_player_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          ld_clr,
    input  logic          ld_push,
    input  logic [2:0]    ld_cmd,
    input  logic [TW-1:0] ld_time,
    output logic          ld_ack,
    input  logic          play_req,
    input  logic [2:0]    play_cmd,
    input  logic          abort,
    output logic          busy,
    output logic          beep,
    output logic          done,
    output logic          err,
    output logic [3:0]    cnt_o
);

    state_e        state_q, state_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [BW-1:0] bl_q, bl_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          match;
    logic [TW-1:0] slot_t;
    logic [CW-1:0] run_cnt;

    pattern_store u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_clr   (ld_clr),
        .ld_push  (ld_push),
        .ld_cmd   (ld_cmd),
        .ld_time  (ld_time),
        .lock     (state_q == ST_RUN),
        .lock_cmd (cmd_q),
        .ld_ack   (ld_ack),
        .rd_cmd   (cmd_q),
        .rd_idx   (idx_q),
        .rd_time  (slot_t),
        .rd_cnt   (run_cnt),
        .q_cmd    (play_cmd),
        .q_cnt    (cnt_o)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        bl_d    = bl_q;
        err_d   = err_q;
        done_d  = 1'b0;
        match   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play_req) begin
                    if (cmd_ok(play_cmd) && cnt_o != '0) begin
                        cmd_d   = play_cmd;
                        tcnt_d  = '0;
                        idx_d   = '0;
                        bl_d    = '0;
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    bl_d    = '0;
                    state_d = ST_FIN;
                end else if (idx_q == run_cnt && bl_q == '0) begin
                    state_d = ST_FIN;
                end else if (tcnt_q == '1) begin
                    bl_d    = '0;
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (tick) begin
                    // a match reloads the timer even mid-beep, so close claps merge
                    match = (idx_q < run_cnt) && (tcnt_q == slot_t);
                    if (match) begin
                        bl_d  = BW'(BEEP_TICKS);
                        idx_d = idx_q + 1'b1;
                    end else if (bl_q != '0) begin
                        bl_d = bl_q - 1'b1;
                    end
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_FIN) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NONE;
            tcnt_q  <= '0;
            idx_q   <= '0;
            bl_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            bl_q    <= bl_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign beep = (state_q == ST_RUN) && (bl_q != '0) && !abort;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_rhythm_player.sv
// Randomised bench for rhythm_player against a queue-based pattern/beep model.
module tb_rhythm_player;
    import rhythm_player_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic       ld_clr = 1'b0, ld_push = 1'b0, play_req = 1'b0, abort = 1'b0;
    logic [2:0] ld_cmd = '0, play_cmd = '0;
    logic [7:0] ld_time = '0;
    logic       ld_ack, busy, beep, done, err;
    logic [3:0] cnt_o;

    int n_chk = 0, n_fail = 0;
    int q_pat [8][$];
    bit model_busy = 0;
    int model_cmd = 0;
    int nbeep = 0;
    bit prev_beep = 0;

    always #5 clk = ~clk;

    rhythm_player dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ld_clr(ld_clr), .ld_push(ld_push),
        .ld_cmd(ld_cmd), .ld_time(ld_time), .ld_ack(ld_ack), .play_req(play_req),
        .play_cmd(play_cmd), .abort(abort), .busy(busy), .beep(beep), .done(done),
        .err(err), .cnt_o(cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit valid_cmd(input int c);
        return c >= 1 && c <= 4;
    endfunction

    // beep is high after tick k iff some stored clap t has t <= k < t+BEEP_TICKS
    function automatic bit exp_beep(input int c, input int k);
        foreach (q_pat[c][i])
            if (q_pat[c][i] <= k && k < q_pat[c][i] + BEEP_TICKS) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input bit clr, input int c, input int t);
        bit acc;
        acc = valid_cmd(c) && !(model_busy && c == model_cmd);
        if (clr) begin
            if (acc) q_pat[c].delete();
        end else begin
            acc = acc && q_pat[c].size() < SLOTS &&
                  (q_pat[c].size() == 0 || t > q_pat[c][$] + MIN_GAP);
            if (acc) q_pat[c].push_back(t);
        end
        ld_clr = clr; ld_push = !clr; ld_cmd = 3'(c); ld_time = 8'(t);
        @(negedge clk);
        ld_clr = 1'b0; ld_push = 1'b0;
        check($sformatf("ld_ack c%0d t%0d clr%0d", c, t, clr), ld_ack, acc);
    endtask

    task automatic check_cnts();
        for (int c = 0; c < 8; c++) begin
            play_cmd = 3'(c);
            #1;
            check($sformatf("cnt_o c%0d", c), cnt_o, valid_cmd(c) ? q_pat[c].size() : 0);
        end
        @(negedge clk);
    endtask

    task automatic play_start(input int c, output bit ok);
        ok = valid_cmd(c) && q_pat[c].size() > 0;
        play_cmd = 3'(c); play_req = 1'b1;
        @(negedge clk);
        play_req = 1'b0;
        nbeep = 0; prev_beep = 0;
        if (ok) begin
            model_busy = 1; model_cmd = c;
            check("busy_on", busy, 1);
            check("err_cleared", err, 0);
            check("beep_before_tick", beep, 0);
        end else begin
            check("bad_done", done, 1);
            check("bad_err", err, 1);
            check("bad_busy", busy, 0);
            @(negedge clk);
            check("bad_done_1cyc", done, 0);
            check("bad_busy_after", busy, 0);
            check("bad_err_sticky", err, 1);
        end
    endtask

    task automatic tick_chk(input int c, input int k);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check($sformatf("beep c%0d k%0d", c, k), beep, exp_beep(c, k));
        if (beep && !prev_beep) nbeep++;
        prev_beep = beep;
    endtask

    task automatic wait_done(input int c);
        bit seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_seen", seen, 1);
        check("done_err", err, 0);
        check("done_busy", busy, 0);
        check("beep_count", nbeep, q_pat[c].size());
        model_busy = 0;
        @(negedge clk);
        check("done_pulse_end", done, 0);
    endtask

    task automatic play_full(input int c);
        bit ok;
        play_start(c, ok);
        if (ok) begin
            for (int k = 0; k <= q_pat[c][$] + BEEP_TICKS; k++) tick_chk(c, k);
            wait_done(c);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int t;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_beep", beep, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ack", ld_ack, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnts();

        // basic playback of Ready {0,10,30}
        load(0, 1, 0); load(0, 1, 10); load(0, 1, 30);
        play_full(1);

        // gap rule on Find
        load(0, 2, 10); load(0, 2, 14); load(0, 2, 16);
        check_cnts();

        // empty pattern and invalid command
        load(1, 4, 0);
        play_full(4);
        play_full(7);
        check("err_sticky_idle", err, 1);

        // abort at tick 12 of {0,20}
        load(1, 2, 0); load(0, 2, 0); load(0, 2, 20);
        play_start(2, ok);
        check("err_cleared_by_play", err, 0);
        for (int k = 0; k < 12; k++) tick_chk(2, k);
        abort = 1'b1; tick = 1'b1;
        #1;
        check("abort_beep_now", beep, 0);
        @(negedge clk);
        abort = 1'b0; tick = 1'b0;
        model_busy = 0;
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        for (int k = 0; k < 12; k++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            check("abort_no_beep", beep, 0);
            check("abort_no_done", done, 0);
        end

        // loads during playback, then reset mid-run
        play_start(1, ok);
        for (int k = 0; k < 6; k++) tick_chk(1, k);
        load(0, 2, 40);
        load(0, 1, 200);
        load(1, 1, 0);
        for (int k = 6; k < 12; k++) tick_chk(1, k);
        check("beep_before_rst", beep, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_beep", beep, 0);
        check("rst_mid_busy", busy, 0);
        for (int c = 0; c < 8; c++) q_pat[c].delete();
        model_busy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnts();

        // capacity: 11 increasing pushes to Return
        t = $urandom_range(0, 5);
        for (int i = 0; i < 11; i++) begin
            load(0, 3, t);
            t += $urandom_range(6, 18);
        end
        check_cnts();
        play_full(3);

        // random load traffic then random playbacks
        for (int i = 0; i < 60; i++)
            load($urandom_range(0, 9) == 0, $urandom_range(0, 7), $urandom_range(0, 200));
        check_cnts();
        for (int i = 0; i < 4; i++) play_full($urandom_range(0, 5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
